bus_arbiter_mux: RTL and testbench
==================================

Name: bus_arbiter_mux

Overview:
- Parametrised successor to the datapath bus multiplexer. It selects one of N_SRC source words onto the shared CPU bus from per-source "out" enables.
- Adds an explicit hold register for idle cycles, so no latch is inferred.
- Adds an optional registered output stage.
- Adds multi-driver conflict detection: a sticky flag plus a saturating counter.
- Sits between the register file / HI / LO / Z sources and all bus consumers (MDR, Y, IR, registers).

Parameters:
- WIDTH, 32, bus word width in bits.
- N_SRC, 20, number of bus sources (R0-R15, HI, LO, Zlow, Zhigh); must be >= 2.
- REGISTERED, 0, 0 = combinational bus with idle hold; 1 = bus_out registered, one-cycle latency.
- CNT_W, 8, width of the conflict counter.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- src_data  in  N_SRC*WIDTH  packed source words; source i occupies bits [i*WIDTH +: WIDTH].
- src_out  in  N_SRC  per-source bus-drive enables (the Rnout/HIout/LOout/Zlowout/Zhighout set).
- err_clr  in  1  synchronous clear of conflict and conflict_cnt.
- bus_out  out  WIDTH  bus value.
- bus_valid  out  1  at least one source drove the bus this cycle (REGISTERED=0) or last cycle (REGISTERED=1).
- bus_src  out  clog2(N_SRC)  index of the most recent winning source.
- conflict  out  1  sticky flag: more than one src_out was asserted in some cycle.
- conflict_cnt  out  CNT_W  number of conflict cycles, saturating.

Behaviour:
- Reset (clear=0, asynchronous, effective immediately, including mid-transfer):
  - hold_reg, bus_out register, bus_src, conflict and conflict_cnt all go to 0.
  - bus_valid = 0 in both modes.
- Winner selection:
  - The highest asserted index of src_out wins (Zhigh > Zlow > LO > HI > R15 > ... > R0).
  - This preserves last-assignment-wins priority.
  - any_sel = OR of src_out. multi_sel = popcount(src_out) > 1.
- REGISTERED=0:
  - bus_out = src_data[winner] combinationally when any_sel=1, otherwise bus_out = hold_reg.
  - hold_reg <= src_data[winner] on every rising edge where any_sel=1; otherwise hold_reg is unchanged.
  - bus_valid = any_sel, combinational.
  - Zero latency from src_out/src_data to bus_out.
- REGISTERED=1:
  - On a rising edge with any_sel=1: bus_out <= src_data[winner] and bus_valid <= 1.
  - On a rising edge with any_sel=0: bus_out holds and bus_valid <= 0.
  - Latency is exactly one clock.
- bus_src: <= winner index on each edge where any_sel=1; otherwise it holds. It is identical in both modes.
- Idle with no prior drive: bus_out = 0, the reset value of hold_reg.
- Conflict detection:
  - On an edge with multi_sel=1: conflict <= 1 and conflict_cnt <= conflict_cnt+1.
  - conflict_cnt saturates at 2^CNT_W-1 and never wraps.
  - Data is still delivered from the highest-index source.
- err_clr handling:
  - err_clr=1 with multi_sel=0: conflict <= 0 and conflict_cnt <= 0.
  - err_clr=1 with multi_sel=1 in the same cycle: set wins, so conflict <= 1 and conflict_cnt <= 1.
- Outputs never depend on src_data of unselected sources.
- No X propagation when src_out = 0.

Decomposition:
- Shared package bus_pkg contains:
  - BUS_WIDTH = 32 and N_BUS_SRC = 20.
  - Source index constants: SRC_R0..SRC_R15 = 0..15, SRC_HI = 16, SRC_LO = 17, SRC_ZLOW = 18, SRC_ZHIGH = 19.
  - A bus_src_t typedef of width clog2(N_BUS_SRC).
- One sub-module is natural: bus_prio_encoder (N parameter).
  - Inputs: src_out.
  - Outputs: winner index, any_sel and multi_sel, all combinational.

Test Plan:
1. Reset, then clear=1 with src_out=0 -> bus_out=0, bus_valid=0, conflict=0, conflict_cnt=0, bus_src=0 in both modes.
2. REGISTERED=0, src_out[5]=1 with R5 data=0xDEADBEEF for one cycle, then src_out=0 -> bus_out=0xDEADBEEF in the same cycle; the next cycle bus_out still reads 0xDEADBEEF, bus_valid=0, bus_src=5.
3. REGISTERED=1, src_out[17]=1 with LO data=0x00000042 -> bus_out=0x00000042 and bus_valid=1 one edge later, not before.
4. src_out[3] and src_out[18] both asserted (R3=0x11111111, Zlow=0x22222222) -> bus_out=0x22222222, bus_src=18, conflict=1, conflict_cnt=1. Holding this for 300 cycles with CNT_W=8 -> conflict_cnt saturates at 255.
5. err_clr=1 on a quiet cycle -> conflict=0, conflict_cnt=0. err_clr=1 coinciding with a new conflict -> conflict=1, conflict_cnt=1.
6. clear pulsed low mid-transfer (asynchronously, between edges) -> all outputs go to 0 immediately. After release, the first edge with src_out[0]=1 and R0=0x0000ABCD gives bus_out=0x0000ABCD and bus_src=0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the CPU datapath bus: default bus geometry,
// source index assignments and the bus source index type.
package bus_pkg;

  localparam int unsigned BUS_WIDTH = 32;
  localparam int unsigned N_BUS_SRC = 20;

  localparam int unsigned SRC_R0    = 0;
  localparam int unsigned SRC_R1    = 1;
  localparam int unsigned SRC_R2    = 2;
  localparam int unsigned SRC_R3    = 3;
  localparam int unsigned SRC_R4    = 4;
  localparam int unsigned SRC_R5    = 5;
  localparam int unsigned SRC_R6    = 6;
  localparam int unsigned SRC_R7    = 7;
  localparam int unsigned SRC_R8    = 8;
  localparam int unsigned SRC_R9    = 9;
  localparam int unsigned SRC_R10   = 10;
  localparam int unsigned SRC_R11   = 11;
  localparam int unsigned SRC_R12   = 12;
  localparam int unsigned SRC_R13   = 13;
  localparam int unsigned SRC_R14   = 14;
  localparam int unsigned SRC_R15   = 15;
  localparam int unsigned SRC_HI    = 16;
  localparam int unsigned SRC_LO    = 17;
  localparam int unsigned SRC_ZLOW  = 18;
  localparam int unsigned SRC_ZHIGH = 19;

  typedef logic [$clog2(N_BUS_SRC)-1:0] bus_src_t;

endpackage

// File: rtl/bus_arbiter_mux_if.sv
// Bus arbiter/mux signal bundle.
//   master: drives src_data, src_out, err_clr; observes the bus outputs.
//   slave : the arbiter itself; consumes sources, drives bus_out, bus_valid,
//           bus_src, conflict, conflict_cnt.
interface bus_arbiter_mux_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_SRC = 20,
  parameter int unsigned CNT_W = 8
);

  logic [N_SRC*WIDTH-1:0]     src_data;
  logic [N_SRC-1:0]           src_out;
  logic                       err_clr;
  logic [WIDTH-1:0]           bus_out;
  logic                       bus_valid;
  logic [$clog2(N_SRC)-1:0]   bus_src;
  logic                       conflict;
  logic [CNT_W-1:0]           conflict_cnt;

  modport master (
    output src_data, src_out, err_clr,
    input  bus_out, bus_valid, bus_src, conflict, conflict_cnt
  );

  modport slave (
    input  src_data, src_out, err_clr,
    output bus_out, bus_valid, bus_src, conflict, conflict_cnt
  );

endinterface

// File: rtl/bus_prio_encoder.sv
// Highest-index-wins priority encoder over the bus drive enables.
//   src_out   : per-source drive enables
//   winner    : index of the highest asserted enable (0 when none)
//   any_sel   : at least one enable asserted
//   multi_sel : more than one enable asserted
module bus_prio_encoder #(
  parameter int unsigned N = 20
) (
  input  logic [N-1:0]         src_out,
  output logic [$clog2(N)-1:0] winner,
  output logic                 any_sel,
  output logic                 multi_sel
);

  localparam int unsigned W = $clog2(N);

  // Ascending scan: a later hit overwrites the winner, matching the
  // last-assignment-wins priority of the original mux.
  always_comb begin
    winner    = '0;
    any_sel   = 1'b0;
    multi_sel = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (src_out[i]) begin
        if (any_sel) multi_sel = 1'b1;
        any_sel = 1'b1;
        winner  = W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Shared CPU bus multiplexer with idle hold, optional output register and
// multi-driver conflict detection.
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   bus   : slave side of bus_arbiter_mux_if (sources/enables/err_clr in;
//           bus_out, bus_valid, bus_src, conflict, conflict_cnt out)
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter int unsigned WIDTH      = BUS_WIDTH,
  parameter int unsigned N_SRC      = N_BUS_SRC,
  parameter int unsigned REGISTERED = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clock,
  input  logic             clear,
  bus_arbiter_mux_if.slave bus
);

  localparam int unsigned SEL_W = $clog2(N_SRC);

  logic [SEL_W-1:0] winner;
  logic             any_sel;
  logic             multi_sel;
  logic [WIDTH-1:0] win_data;

  logic [WIDTH-1:0] hold_q,     hold_d;
  logic             valid_q,    valid_d;
  logic [SEL_W-1:0] bus_src_q,  bus_src_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  bus_prio_encoder #(.N(N_SRC)) u_enc (
    .src_out   (bus.src_out),
    .winner    (winner),
    .any_sel   (any_sel),
    .multi_sel (multi_sel)
  );

  // winner is 0 when nothing is selected, so this never reads an undriven slice.
  assign win_data = bus.src_data[int'(winner)*WIDTH +: WIDTH];

  // hold_q serves as the idle-hold register in combinational mode and as
  // the output register in registered mode; its update rule is the same.
  always_comb begin
    hold_d     = hold_q;
    valid_d    = any_sel;
    bus_src_d  = bus_src_q;
    conflict_d = conflict_q;
    cnt_d      = cnt_q;

    if (any_sel) begin
      hold_d    = win_data;
      bus_src_d = winner;
    end

    // A new conflict outranks err_clr: the clear is applied, then this
    // cycle's conflict is counted as the first one.
    if (multi_sel) begin
      conflict_d = 1'b1;
      if (bus.err_clr)      cnt_d = CNT_W'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (bus.err_clr) begin
      conflict_d = 1'b0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      hold_q     <= '0;
      valid_q    <= 1'b0;
      bus_src_q  <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      hold_q     <= hold_d;
      valid_q    <= valid_d;
      bus_src_q  <= bus_src_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.bus_out      = (REGISTERED == 0 && any_sel) ? win_data : hold_q;
  assign bus.bus_valid    = (REGISTERED != 0) ? valid_q : any_sel;
  assign bus.bus_src      = bus_src_q;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench driving a combinational (u_dut0) and a registered (u_dut1)
// instance of bus_arbiter_mux with identical stimulus.
module tb_bus_arbiter_mux;
  import bus_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned N = 20;
  localparam int unsigned C = 8;

  logic clock;
  logic clear;
  logic [N*W-1:0] src_data_v;
  logic [N-1:0]   src_out_v;
  logic           err_clr_v;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  bus_arbiter_mux_if #(.WIDTH(W), .N_SRC(N), .CNT_W(C)) if0 ();
  bus_arbiter_mux_if #(.WIDTH(W), .N_SRC(N), .CNT_W(C)) if1 ();

  assign if0.src_data = src_data_v;
  assign if0.src_out  = src_out_v;
  assign if0.err_clr  = err_clr_v;
  assign if1.src_data = src_data_v;
  assign if1.src_out  = src_out_v;
  assign if1.err_clr  = err_clr_v;

  bus_arbiter_mux #(.WIDTH(W), .N_SRC(N), .REGISTERED(0), .CNT_W(C)) u_dut0 (
    .clock (clock),
    .clear (clear),
    .bus   (if0)
  );

  bus_arbiter_mux #(.WIDTH(W), .N_SRC(N), .REGISTERED(1), .CNT_W(C)) u_dut1 (
    .clock (clock),
    .clear (clear),
    .bus   (if1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(input int unsigned idx, input logic [W-1:0] val);
    src_data_v[idx*W +: W] = val;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " m0 bus_out"},  64'(if0.bus_out), 64'h0);
    check({tag, " m0 valid"},    64'(if0.bus_valid), 64'h0);
    check({tag, " m0 bus_src"},  64'(if0.bus_src), 64'h0);
    check({tag, " m0 conflict"}, 64'(if0.conflict), 64'h0);
    check({tag, " m0 cnt"},      64'(if0.conflict_cnt), 64'h0);
    check({tag, " m1 bus_out"},  64'(if1.bus_out), 64'h0);
    check({tag, " m1 valid"},    64'(if1.bus_valid), 64'h0);
    check({tag, " m1 bus_src"},  64'(if1.bus_src), 64'h0);
    check({tag, " m1 conflict"}, 64'(if1.conflict), 64'h0);
    check({tag, " m1 cnt"},      64'(if1.conflict_cnt), 64'h0);
  endtask

  initial begin
    clear      = 1'b0;
    src_data_v = '0;
    src_out_v  = '0;
    err_clr_v  = 1'b0;

    // 1: reset state, then release with nothing driving
    step();
    step();
    clear = 1'b1;
    step();
    check_all_zero("reset");

    // 2: R5 drives for one cycle
    set_src(SRC_R5, 32'hDEADBEEF);
    src_out_v = '0;
    src_out_v[SRC_R5] = 1'b1;
    #1;
    check("t2 m0 same-cycle bus_out", 64'(if0.bus_out), 64'hDEADBEEF);
    check("t2 m0 same-cycle valid",   64'(if0.bus_valid), 64'h1);
    check("t2 m1 pre-edge bus_out",   64'(if1.bus_out), 64'h0);
    check("t2 m1 pre-edge valid",     64'(if1.bus_valid), 64'h0);
    step();
    src_out_v = '0;
    #1;
    check("t2 m0 hold bus_out", 64'(if0.bus_out), 64'hDEADBEEF);
    check("t2 m0 idle valid",   64'(if0.bus_valid), 64'h0);
    check("t2 m0 bus_src",      64'(if0.bus_src), 64'(SRC_R5));
    check("t2 m1 bus_out",      64'(if1.bus_out), 64'hDEADBEEF);
    check("t2 m1 valid",        64'(if1.bus_valid), 64'h1);
    check("t2 m1 bus_src",      64'(if1.bus_src), 64'(SRC_R5));
    step();
    check("t2 m1 idle hold bus_out", 64'(if1.bus_out), 64'hDEADBEEF);
    check("t2 m1 idle valid",        64'(if1.bus_valid), 64'h0);

    // 3: LO drives; registered output changes only after the edge
    set_src(SRC_LO, 32'h00000042);
    src_out_v[SRC_LO] = 1'b1;
    #1;
    check("t3 m0 bus_out",          64'(if0.bus_out), 64'h42);
    check("t3 m1 pre-edge bus_out", 64'(if1.bus_out), 64'hDEADBEEF);
    check("t3 m1 pre-edge valid",   64'(if1.bus_valid), 64'h0);
    step();
    check("t3 m1 bus_out", 64'(if1.bus_out), 64'h42);
    check("t3 m1 valid",   64'(if1.bus_valid), 64'h1);
    check("t3 m1 bus_src", 64'(if1.bus_src), 64'(SRC_LO));
    check("t3 no conflict", 64'(if0.conflict), 64'h0);
    src_out_v = '0;

    // 4: R3 and Zlow together, then held until the counter saturates
    set_src(SRC_R3, 32'h11111111);
    set_src(SRC_ZLOW, 32'h22222222);
    src_out_v[SRC_R3]   = 1'b1;
    src_out_v[SRC_ZLOW] = 1'b1;
    #1;
    check("t4 m0 bus_out",           64'(if0.bus_out), 64'h22222222);
    check("t4 pre-edge conflict",    64'(if0.conflict), 64'h0);
    step();
    check("t4 m1 bus_out",  64'(if1.bus_out), 64'h22222222);
    check("t4 bus_src",     64'(if0.bus_src), 64'(SRC_ZLOW));
    check("t4 conflict",    64'(if0.conflict), 64'h1);
    check("t4 cnt",         64'(if0.conflict_cnt), 64'h1);
    check("t4 m1 cnt",      64'(if1.conflict_cnt), 64'h1);
    step();
    check("t4 cnt after 2", 64'(if0.conflict_cnt), 64'h2);
    repeat (298) @(posedge clock);
    #1;
    check("t4 m0 cnt saturated", 64'(if0.conflict_cnt), 64'd255);
    check("t4 m1 cnt saturated", 64'(if1.conflict_cnt), 64'd255);
    check("t4 conflict sticky",  64'(if1.conflict), 64'h1);

    // single driver does not disturb the sticky state
    src_out_v = '0;
    src_out_v[SRC_R3] = 1'b1;
    step();
    check("t4 single drv conflict", 64'(if0.conflict), 64'h1);
    check("t4 single drv cnt",      64'(if0.conflict_cnt), 64'd255);
    check("t4 single drv m0 out",   64'(if0.bus_out), 64'h11111111);

    // 5: err_clr on a quiet cycle, then coinciding with a new conflict
    src_out_v = '0;
    err_clr_v = 1'b1;
    step();
    check("t5 clr conflict", 64'(if0.conflict), 64'h0);
    check("t5 clr cnt",      64'(if0.conflict_cnt), 64'h0);
    check("t5 m1 clr cnt",   64'(if1.conflict_cnt), 64'h0);
    err_clr_v = 1'b0;
    src_out_v[SRC_R3]   = 1'b1;
    src_out_v[SRC_ZLOW] = 1'b1;
    step();
    step();
    check("t5 cnt before set-wins", 64'(if0.conflict_cnt), 64'h2);
    err_clr_v = 1'b1;
    step();
    check("t5 set-wins conflict", 64'(if0.conflict), 64'h1);
    check("t5 set-wins cnt",      64'(if0.conflict_cnt), 64'h1);
    check("t5 m1 set-wins cnt",   64'(if1.conflict_cnt), 64'h1);
    err_clr_v = 1'b0;

    // 6: asynchronous reset between edges, then first transfer after release
    src_out_v = '0;
    set_src(SRC_HI, 32'h00000055);
    src_out_v[SRC_HI] = 1'b1;
    step();
    check("t6 m1 pre-reset bus_out", 64'(if1.bus_out), 64'h55);
    src_out_v = '0;
    #1;
    check("t6 m0 pre-reset hold", 64'(if0.bus_out), 64'h55);
    clear = 1'b0;
    #1;
    check_all_zero("t6 async");
    clear = 1'b1;
    set_src(SRC_R0, 32'h0000ABCD);
    src_out_v[SRC_R0] = 1'b1;
    step();
    check("t6 m0 bus_out", 64'(if0.bus_out), 64'h0000ABCD);
    check("t6 m1 bus_out", 64'(if1.bus_out), 64'h0000ABCD);
    check("t6 m1 valid",   64'(if1.bus_valid), 64'h1);
    check("t6 bus_src",    64'(if1.bus_src), 64'(SRC_R0));
    src_out_v = '0;
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
